// File: rtl/vrased_log_pkg.sv
// Shared definitions for the VRASED violation logger: source codes,
// buffer update actions and record field offsets.
package vrased_log_pkg;

  // Source codes; the index is also the priority (0 wins).
  localparam int SRC_X_STACK     = 0;
  localparam int SRC_AC          = 1;
  localparam int SRC_ATOM        = 2;
  localparam int SRC_DMA_AC      = 3;
  localparam int SRC_DMA_DET     = 4;
  localparam int SRC_DMA_X_STACK = 5;

  // What the circular buffer does on a given cycle.
  typedef enum logic [2:0] {
    ACT_IDLE,
    ACT_PUSH,
    ACT_POP,
    ACT_PUSHPOP,
    ACT_OVERWRITE,
    ACT_DROP
  } buf_act_e;

  // Record layout, LSB first: wr, en, addr, pc, multi, code, ts.
  function automatic int rec_width(input int ts_w, input int code_w, input int addr_w);
    return ts_w + code_w + 1 + 2*addr_w + 2;
  endfunction

  function automatic int rec_off_wr();
    return 0;
  endfunction

  function automatic int rec_off_en();
    return 1;
  endfunction

  function automatic int rec_off_addr();
    return 2;
  endfunction

  function automatic int rec_off_pc(input int addr_w);
    return 2 + addr_w;
  endfunction

  function automatic int rec_off_multi(input int addr_w);
    return 2 + 2*addr_w;
  endfunction

  function automatic int rec_off_code(input int addr_w);
    return 3 + 2*addr_w;
  endfunction

  function automatic int rec_off_ts(input int code_w, input int addr_w);
    return 3 + 2*addr_w + code_w;
  endfunction

endpackage

// File: rtl/event_log_ram.sv
// Record storage: DEPTH x REC_W, synchronous write, asynchronous read so
// the head record can fall through to the read port.
module event_log_ram #(
  parameter int DEPTH = 64,
  parameter int REC_W = 54,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [REC_W-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [REC_W-1:0] o_rdata
);

  logic [REC_W-1:0] r_mem [DEPTH];

  // Write port; contents are don't-care until written, reads are gated by the caller.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/vrased_event_logger.sv
// Multi-source violation logger: rising-edge detect on monitor reset pulses,
// priority pick, one-cycle capture register, then a circular record buffer
// with a first-word-fall-through valid/ready read port.
module vrased_event_logger
  import vrased_log_pkg::*;
#(
  parameter int NUM_SRC   = 6,
  parameter int CODE_W    = 3,
  parameter int ADDR_W    = 16,
  parameter int TS_W      = 16,
  parameter int DEPTH     = 64,
  parameter int WRAP_MODE = 1,
  localparam int REC_W    = TS_W + CODE_W + 1 + 2*ADDR_W + 2,
  localparam int CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_SRC-1:0]      evt_req,
  input  logic [NUM_SRC*ADDR_W-1:0] evt_addr,
  input  logic [NUM_SRC-1:0]      evt_en,
  input  logic [NUM_SRC-1:0]      evt_wr,
  input  logic [ADDR_W-1:0]       pc,
  input  logic                    clr,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic [REC_W-1:0]        rd_data,
  output logic [CNT_W-1:0]        count,
  output logic                    full,
  output logic                    overflow,
  output logic [15:0]             drop_cnt
);

  localparam int AW      = $clog2(DEPTH);
  localparam int O_WR    = rec_off_wr();
  localparam int O_EN    = rec_off_en();
  localparam int O_ADDR  = rec_off_addr();
  localparam int O_PC    = rec_off_pc(ADDR_W);
  localparam int O_MULTI = rec_off_multi(ADDR_W);
  localparam int O_CODE  = rec_off_code(ADDR_W);
  localparam int O_TS    = rec_off_ts(CODE_W, ADDR_W);

  logic [TS_W-1:0]    r_ts;
  logic [NUM_SRC-1:0] r_req_q;
  logic               r_cap_vld;
  logic [REC_W-1:0]   r_cap_rec;
  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               r_overflow;
  logic [15:0]        r_drop_cnt;

  logic [NUM_SRC-1:0] w_new;
  logic               w_any;
  logic               w_multi;
  logic [CODE_W-1:0]  w_sel;
  logic [ADDR_W-1:0]  w_sel_addr;
  logic               w_sel_en;
  logic               w_sel_wr;
  logic [REC_W-1:0]   w_cap_rec;
  logic               w_pop;
  logic               w_full;
  logic               w_we;
  logic [REC_W-1:0]   w_ram_rd;
  buf_act_e           w_act;

  assign w_new   = evt_req & ~r_req_q;
  assign w_any   = |w_new;
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign w_multi = |(w_new & (w_new - NUM_SRC'(1)));

  // Free-running timestamp, restarted by clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   r_ts <= '0;
    else if (clr) r_ts <= '0;
    else          r_ts <= r_ts + TS_W'(1);
  end

  // Edge history keeps tracking through clr so a held level is not re-logged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_req_q <= '0;
    else        r_req_q <= evt_req;
  end

  // Priority pick: scan high to low so the lowest new index wins.
  always_comb begin
    w_sel      = '0;
    w_sel_addr = '0;
    w_sel_en   = 1'b0;
    w_sel_wr   = 1'b0;
    for (int i = NUM_SRC-1; i >= 0; i--) begin
      if (w_new[i]) begin
        w_sel      = CODE_W'(i);
        w_sel_addr = evt_addr[i*ADDR_W +: ADDR_W];
        w_sel_en   = evt_en[i];
        w_sel_wr   = evt_wr[i];
      end
    end
  end

  // Assemble the record from this cycle's pc, timestamp and winning source.
  always_comb begin
    w_cap_rec                     = '0;
    w_cap_rec[O_WR]               = w_sel_wr;
    w_cap_rec[O_EN]               = w_sel_en;
    w_cap_rec[O_ADDR +: ADDR_W]   = w_sel_addr;
    w_cap_rec[O_PC +: ADDR_W]     = pc;
    w_cap_rec[O_MULTI]            = w_multi;
    w_cap_rec[O_CODE +: CODE_W]   = w_sel;
    w_cap_rec[O_TS +: TS_W]       = r_ts;
  end

  // Capture stage: one record per cycle, discarded by clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cap_vld <= 1'b0;
      r_cap_rec <= '0;
    end else if (clr) begin
      r_cap_vld <= 1'b0;
      r_cap_rec <= '0;
    end else begin
      r_cap_vld <= w_any;
      r_cap_rec <= w_cap_rec;
    end
  end

  assign w_pop  = (r_count != '0) && rd_ready;
  assign w_full = (r_count == CNT_W'(DEPTH));

  // Decide the buffer action; a pop frees a slot so a full buffer loses nothing.
  always_comb begin
    w_act = ACT_IDLE;
    if (r_cap_vld && w_pop)       w_act = ACT_PUSHPOP;
    else if (r_cap_vld && w_full) w_act = (WRAP_MODE != 0) ? ACT_OVERWRITE : ACT_DROP;
    else if (r_cap_vld)           w_act = ACT_PUSH;
    else if (w_pop)               w_act = ACT_POP;
  end

  assign w_we = !clr && (w_act == ACT_PUSH || w_act == ACT_PUSHPOP || w_act == ACT_OVERWRITE);

  // Pointers, occupancy and loss status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (clr) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      case (w_act)
        ACT_PUSH: begin
          r_wr_ptr <= r_wr_ptr + AW'(1);
          r_count  <= r_count + CNT_W'(1);
        end
        ACT_POP: begin
          r_rd_ptr <= r_rd_ptr + AW'(1);
          r_count  <= r_count - CNT_W'(1);
        end
        ACT_PUSHPOP: begin
          r_wr_ptr <= r_wr_ptr + AW'(1);
          r_rd_ptr <= r_rd_ptr + AW'(1);
        end
        ACT_OVERWRITE: begin
          // Full means wr_ptr == rd_ptr: the oldest slot is reused and the head moves on.
          r_wr_ptr   <= r_wr_ptr + AW'(1);
          r_rd_ptr   <= r_rd_ptr + AW'(1);
          r_overflow <= 1'b1;
          if (r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
        end
        ACT_DROP: begin
          r_overflow <= 1'b1;
          if (r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
        end
        default: ;
      endcase
    end
  end

  event_log_ram #(
    .DEPTH (DEPTH),
    .REC_W (REC_W),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_wr_ptr),
    .i_wdata (r_cap_rec),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_ram_rd)
  );

  assign rd_valid = (r_count != '0);
  assign rd_data  = rd_valid ? w_ram_rd : '0;
  assign count    = r_count;
  assign full     = w_full;
  assign overflow = r_overflow;
  assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_vrased_event_logger.sv
// Bench for vrased_event_logger: a wrap-mode and a stop-mode instance
// (DEPTH=4) share stimulus and are checked against queue-based models.
module tb_vrased_event_logger;
  import vrased_log_pkg::*;

  localparam int NS = 6;
  localparam int CW = 3;
  localparam int AW = 16;
  localparam int TW = 16;
  localparam int D  = 4;
  localparam int RW = TW + CW + 1 + 2*AW + 2;
  localparam int SW = 1 + 1 + 1 + 3 + 16 + RW;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NS-1:0]   evt_req;
  logic [NS*AW-1:0] evt_addr;
  logic [NS-1:0]   evt_en;
  logic [NS-1:0]   evt_wr;
  logic [AW-1:0]   pc;
  logic            clr;
  logic            rd_ready;

  logic            w_rd_valid, s_rd_valid;
  logic [RW-1:0]   w_rd_data, s_rd_data;
  logic [2:0]      w_count, s_count;
  logic            w_full, s_full, w_overflow, s_overflow;
  logic [15:0]     w_drop, s_drop;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [RW-1:0] qw[$];
  logic [RW-1:0] qs[$];
  logic [RW-1:0] ev_log[$];
  int            dw, ds;
  bit            ow, os;
  int            ts_m;
  logic [NS-1:0] prev;
  bit            pend;
  logic [RW-1:0] pend_rec;

  always #5 clk = ~clk;

  vrased_event_logger #(.DEPTH(D), .WRAP_MODE(1)) dut_w (
    .clk(clk), .rst_n(rst_n), .evt_req(evt_req), .evt_addr(evt_addr),
    .evt_en(evt_en), .evt_wr(evt_wr), .pc(pc), .clr(clr),
    .rd_valid(w_rd_valid), .rd_ready(rd_ready), .rd_data(w_rd_data),
    .count(w_count), .full(w_full), .overflow(w_overflow), .drop_cnt(w_drop));

  vrased_event_logger #(.DEPTH(D), .WRAP_MODE(0)) dut_s (
    .clk(clk), .rst_n(rst_n), .evt_req(evt_req), .evt_addr(evt_addr),
    .evt_en(evt_en), .evt_wr(evt_wr), .pc(pc), .clr(clr),
    .rd_valid(s_rd_valid), .rd_ready(rd_ready), .rd_data(s_rd_data),
    .count(s_count), .full(s_full), .overflow(s_overflow), .drop_cnt(s_drop));

  // Record field views (layout {ts, code, multi, pc, addr, en, wr})
  function automatic logic [TW-1:0] f_ts(input logic [RW-1:0] r);
    return r[RW-1 -: TW];
  endfunction
  function automatic logic [CW-1:0] f_code(input logic [RW-1:0] r);
    return r[RW-TW-1 -: CW];
  endfunction
  function automatic logic f_multi(input logic [RW-1:0] r);
    return r[2+2*AW];
  endfunction
  function automatic logic [AW-1:0] f_addr(input logic [RW-1:0] r);
    return r[2 +: AW];
  endfunction

  task automatic model_reset();
    qw.delete(); qs.delete();
    dw = 0; ds = 0; ow = 0; os = 0; ts_m = 0; prev = '0; pend = 0; pend_rec = '0;
  endtask

  task automatic rand_bus();
    evt_addr = {$urandom, $urandom, $urandom};
    evt_en   = NS'($urandom);
    evt_wr   = NS'($urandom);
    pc       = AW'($urandom);
  endtask

  // Advance the model on the inputs currently applied, then clock the DUTs.
  task automatic tick();
    logic [NS-1:0] nw;
    int sel, nb;
    bit pw, ps;
    pw = (qw.size() > 0) && rd_ready;
    ps = (qs.size() > 0) && rd_ready;
    if (clr) begin
      qw.delete(); qs.delete();
      dw = 0; ds = 0; ow = 0; os = 0; ts_m = 0; pend = 0;
    end else begin
      if (pw) void'(qw.pop_front());
      if (ps) void'(qs.pop_front());
      if (pend) begin
        if (qw.size() == D) begin
          void'(qw.pop_front()); ow = 1; if (dw < 65535) dw++;
        end
        qw.push_back(pend_rec);
        if (qs.size() == D) begin
          os = 1; if (ds < 65535) ds++;
        end else qs.push_back(pend_rec);
      end
      nw = evt_req & ~prev; sel = -1; nb = 0;
      for (int i = 0; i < NS; i++)
        if (nw[i]) begin nb++; if (sel < 0) sel = i; end
      pend = (sel >= 0);
      if (pend) begin
        pend_rec = {TW'(ts_m), CW'(sel), (nb > 1), pc, evt_addr[sel*AW +: AW], evt_en[sel], evt_wr[sel]};
        ev_log.push_back(pend_rec);
      end
      ts_m = (ts_m + 1) % (1 << TW);
    end
    prev = evt_req;
    @(posedge clk); #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic do_clr();
    clr = 1'b1; tick(); clr = 1'b0;
  endtask

  task automatic do_pop();
    rd_ready = 1'b1; tick(); rd_ready = 1'b0;
  endtask

  // One event on source src: rise for a cycle, then release.
  task automatic fire(input int src);
    rand_bus();
    evt_req = '0; evt_req[src] = 1'b1;
    tick();
    evt_req = '0;
    tick();
  endtask

  task automatic test_reset();
    n_tests++;
    if ({w_rd_valid, w_full, w_overflow, w_count, w_drop, w_rd_data} !== SW'(0)) begin
      n_fail++; $display("FAIL reset_w: got %h want 0", {w_rd_valid, w_full, w_overflow, w_count, w_drop, w_rd_data});
    end
    n_tests++;
    if ({s_rd_valid, s_full, s_overflow, s_count, s_drop, s_rd_data} !== SW'(0)) begin
      n_fail++; $display("FAIL reset_s: got %h want 0", {s_rd_valid, s_full, s_overflow, s_count, s_drop, s_rd_data});
    end
  endtask

  task automatic test_single();
    int base;
    do_clr();
    while (ts_m < 10) tick();
    base = ev_log.size();
    rand_bus();
    evt_req[SRC_AC] = 1'b1;
    tick();
    n_tests++;
    if (w_rd_valid !== 1'b0) begin n_fail++; $display("FAIL single_lat1: rd_valid %b want 0", w_rd_valid); end
    tick();
    n_tests++;
    if (w_rd_valid !== 1'b1) begin n_fail++; $display("FAIL single_lat2: rd_valid %b want 1", w_rd_valid); end
    ticks(3);
    evt_req = '0;
    ticks(2);
    n_tests++;
    if (w_count !== 3'd1 || s_count !== 3'd1) begin n_fail++; $display("FAIL single_count: w %0d s %0d want 1", w_count, s_count); end
    n_tests++;
    if (f_ts(w_rd_data) !== TW'(10)) begin n_fail++; $display("FAIL single_ts: got %0d want 10", f_ts(w_rd_data)); end
    n_tests++;
    if (f_code(w_rd_data) !== CW'(1) || f_multi(w_rd_data) !== 1'b0) begin
      n_fail++; $display("FAIL single_code: code %0d multi %b want 1/0", f_code(w_rd_data), f_multi(w_rd_data));
    end
    n_tests++;
    if (w_rd_data !== ev_log[base]) begin n_fail++; $display("FAIL single_rec: got %h want %h", w_rd_data, ev_log[base]); end
    do_pop();
    n_tests++;
    if (w_rd_valid !== 1'b0 || w_rd_data !== '0 || s_count !== 3'd0) begin
      n_fail++; $display("FAIL single_empty: valid %b data %h want 0", w_rd_valid, w_rd_data);
    end
  endtask

  task automatic test_simul();
    logic [AW-1:0] a3;
    do_clr();
    rand_bus();
    a3 = evt_addr[3*AW +: AW];
    evt_req = '0; evt_req[SRC_DMA_AC] = 1'b1; evt_req[SRC_DMA_X_STACK] = 1'b1;
    ticks(2);
    evt_req = '0;
    tick();
    n_tests++;
    if (w_count !== 3'd1) begin n_fail++; $display("FAIL simul_count: got %0d want 1", w_count); end
    n_tests++;
    if (f_code(w_rd_data) !== CW'(3) || f_multi(w_rd_data) !== 1'b1) begin
      n_fail++; $display("FAIL simul_code: code %0d multi %b want 3/1", f_code(w_rd_data), f_multi(w_rd_data));
    end
    n_tests++;
    if (f_addr(w_rd_data) !== a3) begin n_fail++; $display("FAIL simul_addr: got %h want %h", f_addr(w_rd_data), a3); end
    do_pop();
  endtask

  task automatic test_wrap_stop();
    int base;
    do_clr();
    base = ev_log.size();
    for (int k = 0; k < 6; k++) fire($urandom_range(0, NS-1));
    n_tests++;
    if (w_count !== 3'd4 || w_overflow !== 1'b1 || w_drop !== 16'd2 || w_full !== 1'b1) begin
      n_fail++; $display("FAIL wrap_status: count %0d ovf %b drop %0d full %b want 4/1/2/1", w_count, w_overflow, w_drop, w_full);
    end
    n_tests++;
    if (s_count !== 3'd4 || s_overflow !== 1'b1 || s_drop !== 16'd2 || s_full !== 1'b1) begin
      n_fail++; $display("FAIL stop_status: count %0d ovf %b drop %0d full %b want 4/1/2/1", s_count, s_overflow, s_drop, s_full);
    end
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if (w_rd_data !== ev_log[base+2+k]) begin n_fail++; $display("FAIL wrap_order%0d: got %h want %h", k, w_rd_data, ev_log[base+2+k]); end
      n_tests++;
      if (s_rd_data !== ev_log[base+k]) begin n_fail++; $display("FAIL stop_order%0d: got %h want %h", k, s_rd_data, ev_log[base+k]); end
      do_pop();
    end
    n_tests++;
    if (w_rd_valid !== 1'b0 || s_rd_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_drain: valid w %b s %b want 0", w_rd_valid, s_rd_valid); end
  endtask

  task automatic test_full_pop();
    int base;
    do_clr();
    base = ev_log.size();
    for (int k = 0; k < 4; k++) fire(k);
    rand_bus();
    evt_req = '0; evt_req[SRC_ATOM] = 1'b1;
    tick();
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0; evt_req = '0;
    tick();
    n_tests++;
    if (w_count !== 3'd4 || s_count !== 3'd4 || w_drop !== 16'd0 || s_drop !== 16'd0 || w_overflow !== 1'b0 || s_overflow !== 1'b0) begin
      n_fail++; $display("FAIL fullpop_status: count w %0d s %0d drop w %0d s %0d want 4/4/0/0", w_count, s_count, w_drop, s_drop);
    end
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if (w_rd_data !== ev_log[base+1+k] || s_rd_data !== ev_log[base+1+k]) begin
        n_fail++; $display("FAIL fullpop_order%0d: w %h s %h want %h", k, w_rd_data, s_rd_data, ev_log[base+1+k]);
      end
      do_pop();
    end
  endtask

  task automatic test_clr_capture();
    do_clr();
    fire(0); fire(1);
    rand_bus();
    evt_req = '0; evt_req[SRC_X_STACK] = 1'b1;
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    n_tests++;
    if (w_count !== 3'd0 || w_rd_valid !== 1'b0 || s_rd_valid !== 1'b0) begin
      n_fail++; $display("FAIL clr_empty: count %0d valid %b want 0/0", w_count, w_rd_valid);
    end
    evt_req[SRC_DMA_DET] = 1'b1;
    ticks(3);
    n_tests++;
    if (w_count !== 3'd1) begin n_fail++; $display("FAIL clr_count: got %0d want 1", w_count); end
    n_tests++;
    if (f_ts(w_rd_data) !== TW'(0) || f_code(w_rd_data) !== CW'(4)) begin
      n_fail++; $display("FAIL clr_ts: ts %0d code %0d want 0/4", f_ts(w_rd_data), f_code(w_rd_data));
    end
    evt_req = '0;
    tick();
    do_pop();
  endtask

  task automatic test_random();
    logic [SW-1:0] exp_w, exp_s;
    for (int c = 0; c < 400; c++) begin
      evt_req  = NS'($urandom) & NS'($urandom);
      rand_bus();
      rd_ready = ($urandom_range(0, 2) == 0);
      clr      = ($urandom_range(0, 49) == 0);
      tick();
      exp_w = {qw.size() > 0, qw.size() == D, ow, 3'(qw.size()), 16'(dw), (qw.size() > 0) ? qw[0] : RW'(0)};
      exp_s = {qs.size() > 0, qs.size() == D, os, 3'(qs.size()), 16'(ds), (qs.size() > 0) ? qs[0] : RW'(0)};
      n_tests++;
      if ({w_rd_valid, w_full, w_overflow, w_count, w_drop, w_rd_data} !== exp_w) begin
        n_fail++; $display("FAIL rand_w c%0d: got %h want %h", c, {w_rd_valid, w_full, w_overflow, w_count, w_drop, w_rd_data}, exp_w);
      end
      n_tests++;
      if ({s_rd_valid, s_full, s_overflow, s_count, s_drop, s_rd_data} !== exp_s) begin
        n_fail++; $display("FAIL rand_s c%0d: got %h want %h", c, {s_rd_valid, s_full, s_overflow, s_count, s_drop, s_rd_data}, exp_s);
      end
    end
    evt_req = '0; rd_ready = 1'b0; clr = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    do_clr();
    fire(2); fire(5); fire(1);
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({w_rd_valid, w_full, w_overflow, w_count, w_drop, w_rd_data} !== SW'(0)) begin
      n_fail++; $display("FAIL rstmid_w: got %h want 0", {w_rd_valid, w_full, w_overflow, w_count, w_drop, w_rd_data});
    end
    n_tests++;
    if ({s_rd_valid, s_full, s_overflow, s_count, s_drop, s_rd_data} !== SW'(0)) begin
      n_fail++; $display("FAIL rstmid_s: got %h want 0", {s_rd_valid, s_full, s_overflow, s_count, s_drop, s_rd_data});
    end
    evt_req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    fire(3);
    tick();
    n_tests++;
    if (w_count !== 3'd1 || f_code(w_rd_data) !== CW'(3)) begin
      n_fail++; $display("FAIL rstmid_resume: count %0d code %0d want 1/3", w_count, f_code(w_rd_data));
    end
  endtask

  initial begin
    rst_n = 1'b0; evt_req = '0; evt_addr = '0; evt_en = '0; evt_wr = '0;
    pc = '0; clr = 1'b0; rd_ready = 1'b0;
    model_reset();
    #12;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    model_reset();
    test_single();
    test_simul();
    test_wrap_stop();
    test_full_pop();
    test_clr_capture();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
